// File: rtl/video_pkg.sv
// Shared types, defaults and the RGB332 colour expansion for the video line prefetch block.
package video_pkg;

   typedef enum logic {StIdle, StReq} fetch_state_e;

   localparam int unsigned HResDefault = 800;
   localparam int unsigned VResDefault = 480;

   // Replicate each field's MSBs so full-scale codes reach 8'hFF.
   function automatic logic [23:0] rgb332_expand(input logic [7:0] idx);
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      r = {idx[7:5], idx[7:5], idx[7:6]};
      g = {idx[4:2], idx[4:2], idx[4:3]};
      b = {idx[1:0], idx[1:0], idx[1:0], idx[1:0]};
      return {r, g, b};
   endfunction

endpackage

// File: rtl/line_buffer_2bank.sv
// Ping-pong line buffer: two banks of 16-bit words, one write port, one registered read port.
module line_buffer_2bank #(
   parameter int unsigned Depth = 400,
   parameter int unsigned AddrW = $clog2(Depth)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             we,
   input  logic             wbank,
   input  logic [AddrW-1:0] waddr,
   input  logic [15:0]      wdata,
   input  logic             rbank,
   input  logic [AddrW-1:0] raddr,
   output logic [15:0]      rdata
);

   localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);

   logic [15:0] bank0_mem [Depth];
   logic [15:0] bank1_mem [Depth];
   logic [15:0] rdata_q;

   always_ff @(posedge Clock) begin
      if (we && (waddr <= LastAddr)) begin
         if (wbank) begin
            bank1_mem[waddr] <= wdata;
         end else begin
            bank0_mem[waddr] <= wdata;
         end
      end
   end

   // Out-of-range reads (off-screen columns) hold the last word; the caller blanks them.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         rdata_q <= '0;
      end else if (raddr <= LastAddr) begin
         rdata_q <= rbank ? bank1_mem[raddr] : bank0_mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/video_line_prefetch.sv
// Prefetches the next display line into a ping-pong buffer and maps pixel indices to RGB.
// Define PALETTE_LUT_EN for a 256x24 palette RAM; otherwise indices decode as RGB332.
module video_line_prefetch
   import video_pkg::*;
#(
   parameter int unsigned   H_RES   = HResDefault,
   parameter int unsigned   V_RES   = VResDefault,
   parameter int unsigned   AW      = 20,
   parameter logic [AW-1:0] FB_BASE = '0
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic [9:0]    Column_in,
   input  logic [9:0]    Row_in,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [15:0]   mem_rdata,
   input  logic          pal_we,
   input  logic [7:0]    pal_addr,
   input  logic [23:0]   pal_wdata,
   output logic [7:0]    Red,
   output logic [7:0]    Green,
   output logic [7:0]    Blue,
   output logic          underrun,
   input  logic          underrun_clr
);

   localparam int unsigned      LineWords  = H_RES / 2;
   localparam int unsigned      WcntW      = $clog2(LineWords);
   localparam logic [WcntW-1:0] LastWord   = WcntW'(LineWords - 1);
   localparam logic [9:0]       HResCol    = 10'(H_RES);
   localparam logic [9:0]       VResRow    = 10'(V_RES);
   localparam logic [AW-1:0]    LineWordsA = AW'(LineWords);

   fetch_state_e     state_q, state_d;
   logic [WcntW-1:0] wcnt_q, wcnt_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [9:0]       row_q;
   logic             disp_bank_q, disp_bank_d;
   logic [1:0]       blank_q, blank_d;
   logic             underrun_q, underrun_d;

   logic             row_change;
   logic [9:0]       fetch_row;
   logic             buf_we;
   logic             fill_bank;
   logic [WcntW-1:0] buf_raddr;
   logic [15:0]      buf_rdata;

   logic             pix_black_d, pix_black_q;
   logic             pix_odd_q;
   logic [7:0]       pix_idx;
   logic [23:0]      rgb_q;

   // State register
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q     <= StIdle;
         wcnt_q      <= '0;
         addr_q      <= '0;
         row_q       <= 10'h3FF;
         disp_bank_q <= 1'b0;
         blank_q     <= 2'b11;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         addr_q      <= addr_d;
         row_q       <= Row_in;
         disp_bank_q <= disp_bank_d;
         blank_q     <= blank_d;
         underrun_q  <= underrun_d;
      end
   end

   // Next state: word acceptance first, then a row change overrides (abort and restart).
   always_comb begin
      row_change  = (Row_in != row_q);
      fetch_row   = Row_in + 10'd1;
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      addr_d      = addr_q;
      disp_bank_d = disp_bank_q;
      blank_d     = blank_q;
      underrun_d  = underrun_q;
      buf_we      = 1'b0;

      if (underrun_clr) begin
         underrun_d = 1'b0;
      end

      if ((state_q == StReq) && mem_ack) begin
         buf_we = 1'b1;
         if (wcnt_q == LastWord) begin
            state_d = StIdle;
         end else begin
            wcnt_d = wcnt_q + 1'b1;
            addr_d = addr_q + 1'b1;
         end
      end

      if (row_change) begin
         if (state_q == StReq) begin
            underrun_d = 1'b1;
         end
         disp_bank_d = ~disp_bank_q;
         wcnt_d      = '0;
         // The bank shown so far becomes the new fill bank.
         if (fetch_row < VResRow) begin
            state_d              = StReq;
            addr_d               = FB_BASE + AW'(fetch_row) * LineWordsA;
            blank_d[disp_bank_q] = 1'b0;
         end else begin
            state_d              = StIdle;
            blank_d[disp_bank_q] = 1'b1;
         end
      end
   end

   // Outputs
   always_comb begin
      mem_req  = (state_q == StReq);
      mem_addr = addr_q;
      underrun = underrun_q;
   end

   // An ack coinciding with a row change still lands in the pre-swap fill bank.
   assign fill_bank = ~disp_bank_q;
   assign buf_raddr = WcntW'(Column_in[9:1]);

   line_buffer_2bank #(
      .Depth(LineWords)
   ) u_line_buffer (
      .Clock (Clock),
      .Reset (Reset),
      .we    (buf_we),
      .wbank (fill_bank),
      .waddr (wcnt_q),
      .wdata (mem_rdata),
      .rbank (disp_bank_q),
      .raddr (buf_raddr),
      .rdata (buf_rdata)
   );

   // Stage 1 alongside the buffer read: blanking and byte select.
   always_comb begin
      pix_black_d = (Column_in >= HResCol) || blank_q[disp_bank_q];
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         pix_black_q <= 1'b1;
         pix_odd_q   <= 1'b0;
      end else begin
         pix_black_q <= pix_black_d;
         pix_odd_q   <= Column_in[0];
      end
   end

   assign pix_idx = pix_odd_q ? buf_rdata[15:8] : buf_rdata[7:0];

`ifdef PALETTE_LUT_EN
   logic [23:0] pal_mem [256];

   always_ff @(posedge Clock) begin
      if (pal_we) begin
         pal_mem[pal_addr] <= pal_wdata;
      end
   end

   // Stage 2: palette read; a same-cycle write to the entry returns the old value.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         rgb_q <= '0;
      end else begin
         rgb_q <= pix_black_q ? 24'h000000 : pal_mem[pix_idx];
      end
   end
`else
   logic unused_pal;
   assign unused_pal = ^{pal_we, pal_addr, pal_wdata};

   // Stage 2: RGB332 expansion, registered to keep the same latency as the palette path.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         rgb_q <= '0;
      end else begin
         rgb_q <= pix_black_q ? 24'h000000 : rgb332_expand(pix_idx);
      end
   end
`endif

   assign Red   = rgb_q[23:16];
   assign Green = rgb_q[15:8];
   assign Blue  = rgb_q[7:0];

endmodule

// File: tb/tb_video_line_prefetch.sv
// Directed self-checking bench for video_line_prefetch with a simple req/ack memory responder.
module tb_video_line_prefetch;

`ifdef PALETTE_LUT_EN
   localparam logic [23:0] ExpIdx01 = 24'hFF0000;
   localparam logic [23:0] ExpIdx02 = 24'h00FF00;
   localparam logic [23:0] ExpIdxE0 = 24'h123456;
   localparam logic [23:0] ExpIdx03 = 24'hABCDEF;
`else
   localparam logic [23:0] ExpIdx01 = 24'h000055;
   localparam logic [23:0] ExpIdx02 = 24'h0000AA;
   localparam logic [23:0] ExpIdxE0 = 24'hFF0000;
   localparam logic [23:0] ExpIdx03 = 24'h0000FF;
`endif

   logic        Clock = 1'b0;
   logic        Reset;
   logic [9:0]  Column_in;
   logic [9:0]  Row_in;
   logic        mem_req;
   logic [19:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic        pal_we;
   logic [7:0]  pal_addr;
   logic [23:0] pal_wdata;
   logic [7:0]  Red, Green, Blue;
   logic        underrun;
   logic        underrun_clr;

   int          n_tests = 0;
   int          n_fail  = 0;

   // Responder / monitor state
   int          ack_div   = 1;
   int          div_cnt   = 0;
   logic        force_ack = 1'b0;
   logic [15:0] data_word = 16'h0201;
   int          n_ack = 0;
   int          n_req = 0;
   int          n_gap = 0;
   logic [19:0] first_addr = '0;
   logic [19:0] last_addr  = '0;

   video_line_prefetch u_dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .Column_in    (Column_in),
      .Row_in       (Row_in),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .pal_we       (pal_we),
      .pal_addr     (pal_addr),
      .pal_wdata    (pal_wdata),
      .Red          (Red),
      .Green        (Green),
      .Blue         (Blue),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
   );

   always #5 Clock = ~Clock;

   // Memory: ack on every ack_div-th requesting cycle, data valid with the ack.
   always @(posedge Clock) begin
      #2;
      mem_ack   = force_ack || (mem_req && ((div_cnt % ack_div) == (ack_div - 1)));
      mem_rdata = data_word;
      if (mem_req) div_cnt++;
   end

   always @(negedge Clock) begin
      if (mem_req) n_req++;
      if (mem_req && mem_ack) begin
         if (n_ack == 0) first_addr = mem_addr;
         else if (mem_addr != last_addr + 20'd1) n_gap++;
         last_addr = mem_addr;
         n_ack++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic clear_mon();
      n_ack = 0;
      n_req = 0;
      n_gap = 0;
   endtask

   task automatic wait_idle(input string tag, input int bound);
      for (int k = 0; k < bound && mem_req; k++) tick();
      check_eq(tag, {31'd0, mem_req}, 32'd0);
   endtask

   task automatic wait_acks(input string tag, input int n, input int bound);
      for (int k = 0; k < bound && n_ack < n; k++) tick();
      check_eq(tag, n_ack, n);
   endtask

   // Back-to-back columns; each result appears two cycles after its column.
   task automatic pix_pair(input string tag, input logic [9:0] c0, input logic [9:0] c1,
                           input logic [23:0] e0, input logic [23:0] e1);
      Column_in = c0;
      tick();
      Column_in = c1;
      tick();
      check_eq({tag, "_a"}, {8'd0, Red, Green, Blue}, {8'd0, e0});
      tick();
      check_eq({tag, "_b"}, {8'd0, Red, Green, Blue}, {8'd0, e1});
   endtask

   task automatic pal_write(input logic [7:0] a, input logic [23:0] d);
      pal_we    = 1'b1;
      pal_addr  = a;
      pal_wdata = d;
      tick();
      pal_we    = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      Reset        = 1'b0;
      Column_in    = '0;
      Row_in       = '0;
      pal_we       = 1'b0;
      pal_addr     = '0;
      pal_wdata    = '0;
      underrun_clr = 1'b0;
      tick();
      pal_write(8'h01, 24'hFF0000);
      pal_write(8'h02, 24'h00FF00);
      tick();
      check_eq("rst_req", {31'd0, mem_req}, 32'd0);
      check_eq("rst_addr", {12'd0, mem_addr}, 32'd0);
      check_eq("rst_rgb", {8'd0, Red, Green, Blue}, 32'd0);
      check_eq("rst_underrun", {31'd0, underrun}, 32'd0);

      // Row 0 after reset: fetch row 1 with zero-wait acks.
      clear_mon();
      Reset = 1'b1;
      tick();
      check_eq("row1_req_rise", {31'd0, mem_req}, 32'd1);
      check_eq("row1_addr0", {12'd0, mem_addr}, 32'd400);
      wait_idle("row1_idle", 1000);
      check_eq("row1_acks", n_ack, 400);
      check_eq("row1_req_cycles", n_req, 400);
      check_eq("row1_first", {12'd0, first_addr}, 32'd400);
      check_eq("row1_last", {12'd0, last_addr}, 32'd799);
      check_eq("row1_gaps", n_gap, 0);
      check_eq("row1_underrun", {31'd0, underrun}, 32'd0);

      // Row 1 displayed; row 2 fetch runs alongside.
      clear_mon();
      Row_in = 10'd1;
      tick();
      pix_pair("pix_c0c1", 10'd0, 10'd1, ExpIdx01, ExpIdx02);
      pix_pair("pix_c800c799", 10'd800, 10'd799, 24'h000000, ExpIdx02);
      wait_idle("row2_idle", 1000);
      check_eq("row2_first", {12'd0, first_addr}, 32'd800);
      check_eq("row2_last", {12'd0, last_addr}, 32'd1199);

      // Slow memory, abort after 300 words.
      clear_mon();
      ack_div = 4;
      Row_in  = 10'd2;
      wait_acks("slow_300", 300, 3000);
      Row_in = 10'd3;
      tick();
      check_eq("abort1_underrun", {31'd0, underrun}, 32'd1);
      check_eq("abort1_addr", {12'd0, mem_addr}, 32'd1600);
      underrun_clr = 1'b1;
      tick();
      check_eq("clr_underrun", {31'd0, underrun}, 32'd0);
      Row_in = 10'd4;
      tick();
      underrun_clr = 1'b0;
      check_eq("abort2_set_wins", {31'd0, underrun}, 32'd1);
      check_eq("abort2_addr", {12'd0, mem_addr}, 32'd2000);
      ack_div = 1;
      wait_idle("row5_idle", 1000);

      // Last displayed line: no fetch, next line black.
      clear_mon();
      Row_in = 10'd479;
      tick();
      pix_pair("row479_pix", 10'd0, 10'd1, ExpIdx01, ExpIdx02);
      repeat (8) tick();
      check_eq("row479_no_req", n_req, 0);
      Row_in = 10'd480;
      tick();
      pix_pair("row480_black", 10'd0, 10'd1, 24'h000000, 24'h000000);
      pix_pair("row480_black2", 10'd6, 10'd401, 24'h000000, 24'h000000);
      check_eq("row480_no_req", n_req, 0);

      // Reset in the middle of a fetch at word 137.
      clear_mon();
      Row_in = 10'd100;
      wait_acks("mid_137", 137, 1000);
      Reset = 1'b0;
      #1;
      check_eq("midrst_req", {31'd0, mem_req}, 32'd0);
      check_eq("midrst_addr", {12'd0, mem_addr}, 32'd0);
      check_eq("midrst_underrun", {31'd0, underrun}, 32'd0);
      tick();
      tick();
      check_eq("midrst_rgb", {8'd0, Red, Green, Blue}, 32'd0);
      clear_mon();
      Reset     = 1'b1;
      force_ack = 1'b1;
      tick();
      force_ack = 1'b0;
      check_eq("restart_req", {31'd0, mem_req}, 32'd1);
      check_eq("restart_addr", {12'd0, mem_addr}, 32'd40400);
      wait_idle("restart_idle", 1000);
      check_eq("restart_acks", n_ack, 400);
      check_eq("restart_last", {12'd0, last_addr}, 32'd40799);

      // Colour mapping of 8'hE0 / 8'h03.
      pal_write(8'hE0, 24'h123456);
      pal_write(8'h03, 24'hABCDEF);
      data_word = 16'h03E0;
      Row_in    = 10'd101;
      tick();
      wait_idle("row102_idle", 1000);
      Row_in = 10'd102;
      tick();
      pix_pair("map_e0_03", 10'd10, 10'd11, ExpIdxE0, ExpIdx03);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
